// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types and constants for the instruction fetch stage
package if_stage_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [63:0] PC_INC    = 64'd4;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

    // Sequential PC step; wraps modulo 2^64 with no alignment check.
    function automatic logic [63:0] next_pc(input logic [63:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// rtl/if_stage_id_reg.sv - IF/ID pipeline register with load, hold and flush controls
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic [63:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [63:0] pc,
    output logic [31:0] instr
);

    // Priority: flush > load > hold; with none asserted a bubble is inserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= 64'h0;
            instr <= NOP_INSTR;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            instr <= instr_in;
        end else if (!hold) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with one outstanding memory request
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic [6:0]  Opcode
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic         id_load;
    logic         id_flush;
    logic [31:0]  id_load_instr;

    // Requests are suppressed while reset is sampled.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        id_load       = 1'b0;
        id_flush      = 1'b0;
        id_load_instr = imem_rdata;

        if (branch_taken) begin
            id_flush = 1'b1;
            pc_d     = branch_target;
            buf_d    = NOP_INSTR;
            // An accepted-but-unanswered request must have its response dropped.
            case (state_q)
                FETCH:   state_d = imem_ready  ? DISCARD : FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH   : DISCARD;
                HOLD:    state_d = FETCH;
                DISCARD: state_d = imem_rvalid ? FETCH   : DISCARD;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            buf_d   = imem_rdata;
                            state_d = HOLD;
                        end else begin
                            id_load = 1'b1;
                            pc_d    = next_pc(pc_q);
                            state_d = FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_load       = 1'b1;
                        id_load_instr = buf_q;
                        pc_d          = next_pc(pc_q);
                        state_d       = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (id_load),
        .hold     (stall),
        .flush    (id_flush),
        .pc_in    (pc_q),
        .instr_in (id_load_instr),
        .valid    (id_valid),
        .pc       (id_pc),
        .instr    (id_instr)
    );

    assign Opcode = id_instr[6:0];

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 stall  input  1  hazard hold; freezes PC and IF/ID register.
REQ-005 branch_taken  input  1  redirect request from branch resolution.
REQ-006 branch_target  input  64  redirect PC, valid when branch_taken=1.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  64  request address, equals current PC.
REQ-009 imem_ready  input  1  memory accepts request this cycle when imem_req=1.
REQ-010 imem_rvalid  input  1  read data valid; at most one per accepted request.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 id_pc  output  64  PC of instruction in IF/ID.
REQ-014 id_instr  output  32  instruction in IF/ID.
REQ-015 Opcode  output  7  id_instr[6:0], driven straight to the control unit.

Function
REQ-016 The block SHALL keep at most one memory request outstanding.
REQ-017 FSM states SHALL be FETCH, WAIT, HOLD, DISCARD.
REQ-018 FETCH: imem_req=1, imem_addr=PC; imem_ready=1 SHALL move to WAIT.
REQ-019 WAIT: on imem_rvalid with stall=0, the block SHALL load id_instr=imem_rdata, id_pc=PC, id_valid=1, set PC=PC+4, and return to FETCH.
REQ-020 WAIT: on imem_rvalid with stall=1, the block SHALL buffer imem_rdata and go to HOLD, leaving IF/ID unchanged.
REQ-021 HOLD: imem_req=0; when stall=0 the block SHALL load the buffered word into IF/ID, set PC=PC+4, and go to FETCH.
REQ-022 DISCARD: imem_req=0; the next imem_rvalid SHALL be dropped and the FSM SHALL go to FETCH.
REQ-023 With stall=1 and no redirect, PC, id_valid, id_pc and id_instr SHALL hold their values.
REQ-024 branch_taken SHALL have priority over stall and SHALL set PC=branch_target.
REQ-025 On branch_taken, IF/ID SHALL be flushed: id_valid=0, id_instr=32'h0, so Opcode=0 and all control outputs deassert.
REQ-026 Redirect in FETCH with imem_ready=1 in the same cycle SHALL go to DISCARD; otherwise the FSM stays in FETCH.
REQ-027 Redirect in WAIT without imem_rvalid SHALL go to DISCARD; redirect in WAIT with imem_rvalid SHALL drop the data and go to FETCH.
REQ-028 Redirect in HOLD SHALL drop the buffer and go to FETCH.
REQ-029 Redirect in DISCARD SHALL update PC and stay in DISCARD until rvalid arrives.
REQ-030 Latency: a request accepted in cycle N with rvalid in N+1 SHALL give id_valid=1 in N+2. Peak throughput is one instruction per 2 cycles.
REQ-031 PC arithmetic SHALL be 64-bit unsigned, with wrap modulo 2^64 and no alignment check.
REQ-032 imem_rvalid in FETCH or HOLD SHALL be ignored; this is a protocol error and a bench assertion.

Reset
REQ-033 With rst_n=0 at a clock edge: PC=RESET_PC, state=FETCH, id_valid=0, id_pc=0, id_instr=32'h0, buffer cleared.
REQ-034 Reset SHALL override stall and branch_taken.
REQ-035 A response that was outstanding at reset SHALL NOT be delivered to IF/ID.
REQ-036 imem_req SHALL be 0 in the cycle that rst_n=0 is sampled.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, NOP_INSTR=32'h0, PC_INC=4, and opcode constants (LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011).
REQ-038 The IF/ID pipeline register SHALL be a sub-module named if_id_reg with load, hold and flush controls.

Verification
REQ-039 Reset with RESET_PC=64'h100, then 1-cycle memory -> addresses 100, 104, 108 requested; id_pc follows with the matching rdata, id_valid pulses per REQ-030.
REQ-040 stall=1 for 3 cycles while in WAIT, rvalid arrives -> HOLD, IF/ID unchanged; after stall drops, id_instr = buffered word and PC advances by 4.
REQ-041 branch_taken with target 64'h200 while in WAIT, no rvalid -> DISCARD; the late rdata is not loaded, next imem_addr=200, and Opcode=0 during the flush.
REQ-042 branch_taken and stall=1 together -> PC=200, id_valid=0; branch wins.
REQ-043 rst_n=0 while a request is outstanding, then rvalid arrives -> id_valid stays 0 and the fetch restarts at RESET_PC.
REQ-044 PC=64'hFFFF_FFFF_FFFF_FFFC fetch completes -> next imem_addr=64'h0.
